// File: rtl/apb_reg_bridge.sv
// APB3 slave front-end for the counter register set.
// Turns each APB transfer into a single-cycle wr_en/rd_en strobe with a stable
// addr/wdata, waits out the one-cycle registered read path, and answers
// unmapped addresses with pslverr. Every output comes straight from a flop.
module apb_reg_bridge #(
    parameter int                ADDR_W   = 10,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] ADDR_MAX = 10'h00C
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        READ_WAIT = 3'd2,
        READ_CAP  = 3'd3,
        ERROR     = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    // Setup phase of a new transfer; only acted on from IDLE.
    logic setup;
    logic unmapped;

    assign setup    = psel && !penable;
    assign unmapped = paddr > ADDR_MAX;

    // State and output registers; reset clears everything, even mid-transfer.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    // Next-state logic: one pass through WRITE/ERROR, two cycles for reads,
    // and a dropped psel sends any in-flight transfer straight back to IDLE.
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (setup) begin
                    if (unmapped)    state_d = ERROR;
                    else if (pwrite) state_d = WRITE;
                    else             state_d = READ_WAIT;
                end
            end
            WRITE:     state_d = IDLE;
            READ_WAIT: state_d = psel ? READ_CAP : IDLE;
            READ_CAP:  state_d = IDLE;
            ERROR:     state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; strobes and pready are one-cycle
    // pulses, addr/wdata/prdata hold until deliberately reloaded.
    always_comb begin
        prdata_d  = prdata_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (setup) begin
                    addr_d  = paddr;
                    wdata_d = pwdata;
                    if (unmapped) begin
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                        prdata_d  = '0;
                    end else if (pwrite) begin
                        wr_en_d  = 1'b1;
                        pready_d = 1'b1;
                    end else begin
                        rd_en_d = 1'b1;
                    end
                end
            end
            READ_CAP: begin
                // rdata is valid now; an aborted read leaves prdata untouched.
                if (psel) begin
                    prdata_d = rdata;
                    pready_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;
    assign wr_en   = wr_en_q;
    assign rd_en   = rd_en_q;
    assign addr    = addr_q;
    assign wdata   = wdata_q;

endmodule
